reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 69 ++++++
 rtl/reg_writeback.sv | 131 +++++++++++++
 tb/tb_reg_writeback.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// ---------------------------------------------------------------------------
// reg_writeback_pkg
// Shared definitions for the register write-back stage:
//   reg_idx_width() - register index width for a given data width
//   X0_IDX          - index of the hard-wired zero register
//   wb_entry_t      - buffered load result {rd, data} at the default width
// ---------------------------------------------------------------------------
package reg_writeback_pkg;

  localparam int DEFAULT_SIZE = 32;
  localparam int X0_IDX       = 0;

  function automatic int reg_idx_width(input int size);
    return $clog2(size);
  endfunction

  typedef struct packed {
    logic [reg_idx_width(DEFAULT_SIZE)-1:0] rd;
    logic [DEFAULT_SIZE-1:0]                data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small FIFO holding load results waiting for a free write-port cycle.
// Head entry is presented combinationally; push and pop may coincide.
// Ports:
//   CLK, RESET_N  clock, asynchronous active-low reset (clears pointers/count)
//   push, wr_data enqueue request and payload
//   pop           dequeue the head entry
//   head          current head entry (valid when !empty)
//   empty, full   occupancy flags
// ---------------------------------------------------------------------------
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_entry_t
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic push,
  input  logic pop,
  input  T     wr_data,
  output T     head,
  output logic empty,
  output logic full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage is not reset; only pointers and occupancy decide what is valid.
  always_ff @(posedge CLK) begin
    if (push) storage[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = storage[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // The write-back arbiter only pushes into a full buffer when it also pops,
  // and only pops a non-empty one.
  a_no_overflow : assert property (@(posedge CLK) disable iff (!RESET_N)
                                   !(push && !pop && full));
  a_no_underflow : assert property (@(posedge CLK) disable iff (!RESET_N)
                                    !(pop && empty));

endmodule

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
// Write-back stage: arbitrates the single register-bank write port between
// single-cycle ALU results (priority, no backpressure) and load results
// (buffered in wb_fifo), and forwards the written value onto the bank read
// data when the bank returns the pre-write value for a same-edge read.
// Ports:
//   CLK, RESET_N                    clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       ALU result
//   mem_valid/mem_rd/mem_data       load result, handshake with mem_ready
//   mem_ready                       load buffer can accept an entry
//   RegWrite/write_reg/writeData    register-bank write port
//   read_reg1/read_reg2             read addresses (also go to the bank)
//   Data1_bank/Data2_bank           bank read data, one cycle after address
//   Data1/Data2                     forwarding-corrected read data
//   mem_pending                     load buffer is non-empty
// ---------------------------------------------------------------------------
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int MEM_DEPTH = 2
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           alu_valid,
  input  logic [reg_idx_width(SIZE)-1:0] alu_rd,
  input  logic [SIZE-1:0]                alu_data,
  input  logic                           mem_valid,
  input  logic [reg_idx_width(SIZE)-1:0] mem_rd,
  input  logic [SIZE-1:0]                mem_data,
  output logic                           mem_ready,
  output logic                           RegWrite,
  output logic [reg_idx_width(SIZE)-1:0] write_reg,
  output logic [SIZE-1:0]                writeData,
  input  logic [reg_idx_width(SIZE)-1:0] read_reg1,
  input  logic [reg_idx_width(SIZE)-1:0] read_reg2,
  input  logic [SIZE-1:0]                Data1_bank,
  input  logic [SIZE-1:0]                Data2_bank,
  output logic [SIZE-1:0]                Data1,
  output logic [SIZE-1:0]                Data2,
  output logic                           mem_pending
);

  localparam int IDX_W = reg_idx_width(SIZE);
  localparam logic [IDX_W-1:0] X0 = IDX_W'(X0_IDX);

  // Same layout as wb_entry_t, sized for this instance's SIZE.
  typedef struct packed {
    logic [IDX_W-1:0] rd;
    logic [SIZE-1:0]  data;
  } entry_t;

  entry_t           load_in;
  entry_t           head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             alu_sel;
  logic             deq;
  logic             accept;
  logic             bypass;
  logic             enq;
  logic             hit1_q;
  logic             hit2_q;
  logic [SIZE-1:0]  wdata_q;

  // Write-port arbitration. Every selection is qualified with RESET_N so the
  // port stays idle during reset even if the sources are still active.
  // A full buffer still accepts a load in a cycle where its head drains.
  always_comb begin
    alu_sel      = RESET_N && alu_valid && (alu_rd != X0);
    deq          = RESET_N && !alu_sel && !fifo_empty;
    mem_ready    = !fifo_full || deq;
    accept       = mem_valid && mem_ready;
    bypass       = RESET_N && accept && fifo_empty && !alu_sel && (mem_rd != X0);
    enq          = RESET_N && accept && (mem_rd != X0) && !bypass;
    load_in.rd   = mem_rd;
    load_in.data = mem_data;

    RegWrite  = 1'b0;
    write_reg = '0;
    writeData = '0;
    if (alu_sel) begin
      RegWrite  = 1'b1;
      write_reg = alu_rd;
      writeData = alu_data;
    end else if (deq) begin
      RegWrite  = 1'b1;
      write_reg = head.rd;
      writeData = head.data;
    end else if (bypass) begin
      RegWrite  = 1'b1;
      write_reg = mem_rd;
      writeData = mem_data;
    end
  end

  wb_fifo #(
    .DEPTH (MEM_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (enq),
    .pop     (deq),
    .wr_data (load_in),
    .head    (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign mem_pending = !fifo_empty;

  // The bank samples the read address on the same edge it performs the
  // write, so it returns the old value; remember the write to patch it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hit1_q  <= 1'b0;
      hit2_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      hit1_q  <= RegWrite && (write_reg == read_reg1) && (write_reg != X0);
      hit2_q  <= RegWrite && (write_reg == read_reg2) && (write_reg != X0);
      wdata_q <= writeData;
    end
  end

  assign Data1 = hit1_q ? wdata_q : Data1_bank;
  assign Data2 = hit2_q ? wdata_q : Data2_bank;

endmodule

// File: tb/tb_reg_writeback.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback
// Self-checking bench for reg_writeback (SIZE=32, MEM_DEPTH=2). A register
// bank model with read-old-value-on-same-edge behaviour is attached to the
// DUT; a reference model (load queue + architectural register array) predicts
// the write port, handshake flags and the corrected read data every cycle.
// ---------------------------------------------------------------------------
module tb_reg_writeback;

  localparam int SIZE  = 32;
  localparam int DEPTH = 2;
  localparam int IDX_W = 5;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             alu_valid;
  logic [IDX_W-1:0] alu_rd;
  logic [SIZE-1:0]  alu_data;
  logic             mem_valid;
  logic [IDX_W-1:0] mem_rd;
  logic [SIZE-1:0]  mem_data;
  logic             mem_ready;
  logic             RegWrite;
  logic [IDX_W-1:0] write_reg;
  logic [SIZE-1:0]  writeData;
  logic [IDX_W-1:0] read_reg1;
  logic [IDX_W-1:0] read_reg2;
  logic [SIZE-1:0]  Data1_bank;
  logic [SIZE-1:0]  Data2_bank;
  logic [SIZE-1:0]  Data1;
  logic [SIZE-1:0]  Data2;
  logic             mem_pending;

  always #5 CLK = ~CLK;

  reg_writeback #(
    .SIZE      (SIZE),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .RegWrite    (RegWrite),
    .write_reg   (write_reg),
    .writeData   (writeData),
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .Data1_bank  (Data1_bank),
    .Data2_bank  (Data2_bank),
    .Data1       (Data1),
    .Data2       (Data2),
    .mem_pending (mem_pending)
  );

  function automatic logic [SIZE-1:0] init_val(input int i);
    return 32'hC0DE_0000 | SIZE'(i * 32'h0101);
  endfunction

  // Register bank: read data appears one cycle after the address and shows
  // the value from before a write on the same edge.
  logic [SIZE-1:0] bank [32];
  logic            bank_ready = 1'b0;

  always @(posedge CLK) begin
    if (!bank_ready) begin
      for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
      bank_ready <= 1'b1;
    end else begin
      Data1_bank <= bank[read_reg1];
      Data2_bank <= bank[read_reg2];
      if (RegWrite) bank[write_reg] <= writeData;
    end
  end

  // Reference model state
  typedef struct {
    logic [IDX_W-1:0] rd;
    logic [SIZE-1:0]  data;
  } load_t;

  load_t            load_q[$];
  logic [SIZE-1:0]  arch [32];
  logic [IDX_W-1:0] prev_rr1;
  logic [IDX_W-1:0] prev_rr2;
  bit               prev_ok = 0;
  bit               check_bank1 = 0;
  logic [SIZE-1:0]  expect_bank1;

  int    compared   = 0;
  int    mismatched = 0;
  string phase      = "reset";

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, tag,
               actual, expected);
    end
  endtask

  // Predict this cycle's outputs from the architectural rules, compare, then
  // advance the model as the clock edge will.
  task automatic evaluateCycle();
    bit              alu_w;
    bit              exp_we;
    bit              exp_ready;
    bit              exp_pend;
    bit              load_taken;
    logic [IDX_W-1:0] exp_rd;
    logic [SIZE-1:0]  exp_data;
    load_t           ld;

    exp_we   = 0;
    exp_rd   = '0;
    exp_data = '0;
    alu_w    = alu_valid && (alu_rd != 0);

    if (!RESET_N) begin
      exp_ready = 1;
      exp_pend  = 0;
      load_q.delete();
    end else begin
      exp_pend   = (load_q.size() > 0);
      exp_ready  = (load_q.size() < DEPTH) || !alu_w;
      load_taken = mem_valid && exp_ready && (mem_rd != 0);
      if (alu_w) begin
        exp_we = 1; exp_rd = alu_rd; exp_data = alu_data;
      end else if (load_q.size() > 0) begin
        ld = load_q.pop_front();
        exp_we = 1; exp_rd = ld.rd; exp_data = ld.data;
      end else if (load_taken) begin
        exp_we = 1; exp_rd = mem_rd; exp_data = mem_data;
        load_taken = 0;
      end
      if (load_taken) begin
        ld.rd = mem_rd; ld.data = mem_data;
        load_q.push_back(ld);
      end
    end

    checkOutput("RegWrite",    64'(RegWrite),    64'(exp_we));
    checkOutput("write_reg",   64'(write_reg),   64'(exp_rd));
    checkOutput("writeData",   64'(writeData),   64'(exp_data));
    checkOutput("mem_ready",   64'(mem_ready),   64'(exp_ready));
    checkOutput("mem_pending", 64'(mem_pending), 64'(exp_pend));

    if (RESET_N && prev_ok) begin
      checkOutput("Data1", 64'(Data1), 64'(arch[prev_rr1]));
      checkOutput("Data2", 64'(Data2), 64'(arch[prev_rr2]));
    end
    if (check_bank1) begin
      checkOutput("Data1_bank_old", 64'(Data1_bank), 64'(expect_bank1));
      check_bank1 = 0;
    end

    if (exp_we) arch[exp_rd] = exp_data;
    prev_rr1 = read_reg1;
    prev_rr2 = read_reg2;
    prev_ok  = 1;
  endtask

  // Drive one cycle of inputs just after the rising edge, check mid-cycle.
  task automatic applyStimulus(input logic rstn,
                               input logic av, input logic [IDX_W-1:0] ar,
                               input logic [SIZE-1:0] ad,
                               input logic mv, input logic [IDX_W-1:0] mr,
                               input logic [SIZE-1:0] md,
                               input logic [IDX_W-1:0] r1,
                               input logic [IDX_W-1:0] r2);
    RESET_N   = rstn;
    alu_valid = av;
    alu_rd    = ar;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mr;
    mem_data  = md;
    read_reg1 = r1;
    read_reg2 = r2;
    @(negedge CLK);
    evaluateCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input logic [IDX_W-1:0] r1,
                      input logic [IDX_W-1:0] r2);
    for (int i = 0; i < n; i++)
      applyStimulus(1, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) arch[i] = init_val(i);
    $display("[TB] reg_writeback bench starting");

    phase = "reset";
    applyStimulus(0, 1, 5, 32'h1, 1, 6, 32'h2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 1, 2);

    // ALU write forwarded over the bank's stale read.
    phase = "alu_forward";
    applyStimulus(1, 1, 5, 32'hA5A5_A5A5, 0, 0, 0, 5, 0);
    expect_bank1 = init_val(5);
    check_bank1  = 1;
    idle(1, 5, 0);

    // Load and ALU in the same cycle: ALU first, load next.
    phase = "alu_then_load";
    applyStimulus(1, 1, 4, 32'h44, 1, 3, 32'h11, 3, 4);
    idle(3, 3, 4);

    // ALU busy every cycle, three loads offered: buffer fills at two.
    phase = "backpressure";
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 5'(10 + i), 32'h1000 + 32'(i), 1, 5'(7 + i),
                    32'h70 + 32'(i), 7, 8);
    idle(4, 7, 8);

    // Full buffer drains its head while accepting a new load.
    phase = "full_swap";
    applyStimulus(1, 1, 1, 32'hAAAA, 1, 12, 32'hC12, 12, 13);
    applyStimulus(1, 1, 2, 32'hBBBB, 1, 13, 32'hC13, 12, 13);
    applyStimulus(1, 0, 0, 0, 1, 14, 32'hC14, 13, 14);
    idle(4, 13, 14);

    // Writes to x0 from either source are dropped and never forwarded.
    phase = "x0_drop";
    applyStimulus(1, 1, 0, 32'hFFFF, 1, 0, 32'h1234, 0, 0);
    idle(2, 0, 0);

    // Reset with two buffered loads discards them; next load bypasses.
    phase = "reset_midway";
    applyStimulus(1, 1, 1, 32'h5151, 1, 16, 32'hD16, 16, 17);
    applyStimulus(1, 1, 2, 32'h5252, 1, 17, 32'hD17, 16, 17);
    applyStimulus(0, 1, 6, 32'h6666, 1, 18, 32'hD18, 16, 17);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 16, 17);
    applyStimulus(1, 0, 0, 0, 1, 20, 32'hBEEF, 20, 16);
    idle(2, 20, 17);

    // Randomized traffic over a small register window to force collisions.
    phase = "random";
    for (int n = 0; n < 500; n++) begin
      applyStimulus(($urandom_range(0, 63) != 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    $urandom(),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    $urandom(),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(4, 1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
